// File: rtl/conv_pkg.sv
// Shared constants and FSM encoding for the rate-1/N convolutional encoder.
package conv_pkg;
    localparam int K_DEF = 3;
    localparam int N_DEF = 2;
    localparam int K_MIN = 3;
    localparam int K_MAX = 9;
    localparam int N_MIN = 2;
    localparam int N_MAX = 4;

    // G[j] = G[j*K +: K]; bit K-1 of each generator taps the newest input.
    localparam logic [N_DEF*K_DEF-1:0] G_DEF = {3'b101, 3'b111};

    typedef enum logic {
        DATA = 1'b0,
        TAIL = 1'b1
    } state_e;
endpackage

// File: rtl/conv_encoder_n_if.sv
// Input bit stream plus serial coded output stream, both valid/ready.
interface conv_encoder_n_if;
    logic in_bit;
    logic in_valid;
    logic in_last;
    logic in_ready;
    logic out_bit;
    logic out_valid;
    logic out_last;
    logic out_ready;

    modport slave (
        input  in_bit, in_valid, in_last, out_ready,
        output in_ready, out_bit, out_valid, out_last
    );

    modport master (
        output in_bit, in_valid, in_last, out_ready,
        input  in_ready, out_bit, out_valid, out_last
    );
endinterface

// File: rtl/conv_parity.sv
// Combinational codeword generation: c[j] = XOR-reduce(G[j] & v).
module conv_parity
    import conv_pkg::*;
#(
    parameter int              K = K_DEF,
    parameter int              N = N_DEF,
    parameter logic [N*K-1:0]  G = G_DEF
) (
    input  logic [K-1:0] i_v,
    output logic [N-1:0] o_c
);
    for (genvar j = 0; j < N; j++) begin : g_gen
        assign o_c[j] = ^(G[j*K +: K] & i_v);
    end
endmodule

// File: rtl/conv_encoder_n.sv
// Rate-1/N convolutional encoder with optional zero-tail termination and a
// one-symbol serializer that keeps the output gapless at one bit per cycle.
module conv_encoder_n
    import conv_pkg::*;
#(
    parameter int              K         = K_DEF,
    parameter int              N         = N_DEF,
    parameter logic [N*K-1:0]  G         = G_DEF,
    parameter int              TERMINATE = 1
) (
    input  logic              clk,
    input  logic              rst,
    conv_encoder_n_if.slave   bus
);
    localparam int              IDX_W    = $clog2(N);
    localparam int              TC_W     = $clog2(K);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [TC_W-1:0]  TC_LAST  = TC_W'(K - 2);

    if (K < K_MIN || K > K_MAX || N < N_MIN || N > N_MAX ||
        TERMINATE < 0 || TERMINATE > 1) begin : g_bad_param
        $error("conv_encoder_n: K, N or TERMINATE out of range");
    end

    state_e           r_state;
    state_e           w_state_nxt;
    logic [K-2:0]     r_s;
    logic [N-1:0]     r_buf;
    logic             r_full;
    logic [IDX_W-1:0] r_idx;
    logic [TC_W-1:0]  r_tcnt;
    logic             r_fin;

    logic             w_can_load;
    logic             w_load;
    logic             w_final;
    logic             w_x;
    logic             w_in_ready;
    logic [K-1:0]     w_v;
    logic [N-1:0]     w_c;

    // A new symbol may enter as the last bit of the current one drains.
    assign w_can_load = !r_full || (bus.out_ready && r_idx == IDX_LAST);
    assign w_v        = {w_x, r_s};

    conv_parity #(.K(K), .N(N), .G(G)) u_parity (
        .i_v (w_v),
        .o_c (w_c)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= DATA;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_load      = 1'b0;
        w_final     = 1'b0;
        w_x         = 1'b0;
        case (r_state)
            DATA: begin
                w_in_ready = w_can_load;
                w_x        = bus.in_bit;
                w_load     = bus.in_valid && w_can_load;
                if (w_load && bus.in_last) begin
                    if (TERMINATE != 0) w_state_nxt = TAIL;
                    else                w_final     = 1'b1;
                end
            end
            TAIL: begin
                w_load = w_can_load;
                if (w_load && r_tcnt == TC_LAST) begin
                    w_final     = 1'b1;
                    w_state_nxt = DATA;
                end
            end
            default: w_state_nxt = DATA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s    <= '0;
            r_buf  <= '0;
            r_full <= 1'b0;
            r_idx  <= '0;
            r_tcnt <= '0;
            r_fin  <= 1'b0;
        end else begin
            if (w_load) begin
                r_buf  <= w_c;
                r_full <= 1'b1;
                r_idx  <= '0;
                r_fin  <= w_final;
                // Final symbol of a frame returns the trellis to the zero state.
                r_s    <= w_final ? '0 : {w_x, r_s[K-2:1]};
            end else if (r_full && bus.out_ready) begin
                if (r_idx == IDX_LAST) begin
                    r_full <= 1'b0;
                    r_idx  <= '0;
                end else begin
                    r_idx  <= r_idx + IDX_W'(1);
                end
            end
            if (r_state == TAIL && w_load)
                r_tcnt <= (r_tcnt == TC_LAST) ? '0 : r_tcnt + TC_W'(1);
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_full;
    assign bus.out_bit   = r_full & r_buf[r_idx];
    assign bus.out_last  = r_full & r_fin & (r_idx == IDX_LAST);
endmodule

// File: tb/tb_conv_encoder_n.sv
// Directed and model-checked bench for conv_encoder_n (K=3 both tail modes, K=7).
module tb_conv_encoder_n;
    localparam logic [13:0] G7 = {7'o171, 7'o133};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_encoder_n_if if3 ();
    conv_encoder_n_if if3t ();
    conv_encoder_n_if if7 ();

    conv_encoder_n #(.TERMINATE(1)) u_t1 (.clk(clk), .rst(rst), .bus(if3));
    conv_encoder_n #(.TERMINATE(0)) u_t0 (.clk(clk), .rst(rst), .bus(if3t));
    conv_encoder_n #(.K(7), .N(2), .G(G7), .TERMINATE(1)) u_k7 (.clk(clk), .rst(rst), .bus(if7));

    int n_chk = 0;
    int n_err = 0;

    bit q_ib[$];
    bit q_il[$];
    bit q_eb[$];
    bit q_el[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        q_ib.delete(); q_il.delete(); q_eb.delete(); q_el.delete();
    endtask

    task automatic push_in(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            q_ib.push_back(bits[i]);
            q_il.push_back(i == 0);
        end
    endtask

    task automatic push_exp(input logic [63:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            q_eb.push_back(bits[i]);
            q_el.push_back(i == 0);
        end
    endtask

    // Reference encoder: st[k-2] holds the most recent past bit.
    task automatic gen_exp(input int k, input int n, input logic [63:0] g, input bit term);
        logic [15:0] st;
        logic [15:0] v;
        logic [63:0] gj;
        logic        x;
        int          nsym;
        st = '0;
        q_eb.delete(); q_el.delete();
        foreach (q_ib[i]) begin
            nsym = (q_il[i] && term) ? k : 1;
            for (int t = 0; t < nsym; t++) begin
                x  = (t == 0) ? q_ib[i] : 1'b0;
                v  = ({15'b0, x} << (k - 1)) | st;
                for (int j = 0; j < n; j++) begin
                    gj = (g >> (j * k)) & ((64'd1 << k) - 64'd1);
                    q_eb.push_back(^(gj[15:0] & v));
                    q_el.push_back(q_il[i] && (t == nsym - 1) && (j == n - 1));
                end
                st = (st >> 1) | ({15'b0, x} << (k - 2));
            end
            if (q_il[i]) st = '0;
        end
    endtask

    task automatic run(virtual conv_encoder_n_if vif, input bit rnd, input bit term, input string tag);
        int   ip = 0;
        int   op = 0;
        int   cyc = 0;
        int   gaps = 0;
        bit   started = 0;
        bit   pend = 0;
        bit   stalled = 0;
        logic sb = 0;
        logic sl = 0;
        while (op < q_eb.size() && cyc < 20000) begin
            @(negedge clk);
            if (stalled) begin
                chk({tag, "_stall_valid"}, vif.out_valid, 1);
                chk({tag, "_stall_bit"}, vif.out_bit, sb);
                chk({tag, "_stall_last"}, vif.out_last, sl);
            end
            vif.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ip < q_ib.size()) begin
                vif.in_valid = 1'b1;
                vif.in_bit   = q_ib[ip];
                vif.in_last  = q_il[ip];
            end else begin
                vif.in_valid = 1'b0;
                vif.in_bit   = 1'b0;
                vif.in_last  = 1'b0;
            end
            #1;
            if (pend && !(vif.out_valid && vif.out_ready && vif.out_last))
                chk({tag, "_tail_in_ready"}, vif.in_ready, 0);
            if (vif.out_valid) started = 1;
            else if (started) gaps++;
            if (vif.out_valid && vif.out_ready) begin
                chk({tag, "_bit"}, vif.out_bit, q_eb[op]);
                chk({tag, "_last"}, vif.out_last, q_el[op]);
                op++;
                if (vif.out_last) pend = 0;
            end
            stalled = vif.out_valid && !vif.out_ready;
            sb = vif.out_bit;
            sl = vif.out_last;
            if (vif.in_valid && vif.in_ready) begin
                if (term && vif.in_last) pend = 1;
                ip++;
            end
            cyc++;
        end
        chk({tag, "_timeout"}, (cyc >= 20000), 0);
        chk({tag, "_inputs_taken"}, ip, q_ib.size());
        if (!rnd) chk({tag, "_gaps"}, gaps, 0);
        @(negedge clk);
        vif.in_valid  = 1'b0;
        vif.in_last   = 1'b0;
        vif.out_ready = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        if3.in_bit = 0;  if3.in_valid = 0;  if3.in_last = 0;  if3.out_ready = 0;
        if3t.in_bit = 0; if3t.in_valid = 0; if3t.in_last = 0; if3t.out_ready = 0;
        if7.in_bit = 0;  if7.in_valid = 0;  if7.in_last = 0;  if7.out_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", if3.out_valid, 0);
        chk("rst_out_last", if3.out_last, 0);
        chk("rst_out_bit", if3.out_bit, 0);
        chk("rst_in_ready", if3.in_ready, 1);
        chk("rst_in_ready_k7", if7.in_ready, 1);

        // Frame 1,0,1,1 terminated: 11 10 00 01 01 11.
        clear_q(); push_in(4'b1011, 4); push_exp(12'b111000010111, 12);
        run(if3, 0, 1, "term");

        // Same frame truncated: 11 10 00 01, state left at zero.
        clear_q(); push_in(4'b1011, 4); push_exp(8'b11100001, 8);
        run(if3t, 0, 0, "trunc");
        chk("trunc_state_zero", u_t0.r_s, 0);

        // Random backpressure must not change the coded sequence.
        clear_q(); push_in(4'b1011, 4); push_exp(12'b111000010111, 12);
        run(if3, 1, 1, "stall");

        // Two single-bit frames back to back.
        clear_q(); push_in(1'b1, 1); push_in(1'b1, 1);
        push_exp(6'b111011, 6); push_exp(6'b111011, 6);
        run(if3, 0, 1, "b2b");

        // Reset after the second data bit of an unfinished frame.
        @(negedge clk);
        if3.out_ready = 1'b1; if3.in_valid = 1'b1; if3.in_bit = 1'b1; if3.in_last = 1'b0;
        @(negedge clk);
        if3.in_bit = 1'b0;
        @(negedge clk);
        if3.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", if3.out_valid, 0);
        chk("midrst_out_last", if3.out_last, 0);
        chk("midrst_in_ready", if3.in_ready, 1);
        clear_q(); push_in(4'b1011, 4); push_exp(12'b111000010111, 12);
        run(if3, 0, 1, "postrst");

        // K=7 industry code, 100 random frames against the reference model.
        clear_q();
        for (int f = 0; f < 100; f++) begin
            int len;
            len = $urandom_range(1, 20);
            for (int b = 0; b < len; b++) begin
                q_ib.push_back(1'($urandom_range(0, 1)));
                q_il.push_back(b == len - 1);
            end
        end
        gen_exp(7, 2, {50'b0, G7}, 1);
        run(if7, 1, 1, "k7");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/conv_encoder_n.md
CONV_ENCODER_N -- requirements
Module: conv_encoder_n

Interface
REQ-001 SHALL have parameter K, default 3: constraint length, legal range 3..9.
REQ-002 SHALL have parameter N, default 2: code outputs per input bit (rate 1/N), legal range 2..4.
REQ-003 SHALL have parameter G, default {3'b101, 3'b111}: N*K-bit packed generators. G[j] = G[j*K +: K]. Bit K-1 taps the newest input.
REQ-004 SHALL have parameter TERMINATE, default 1: 1 = append K-1 zero tail bits per frame; 0 = truncated frame.
REQ-005 SHALL have port clk, input, 1: sole clock. All logic on posedge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port in_bit, input, 1: data bit.
REQ-008 SHALL have port in_valid, input, 1: in_bit/in_last valid.
REQ-009 SHALL have port in_last, input, 1: last data bit of frame.
REQ-010 SHALL have port in_ready, output, 1: encoder accepts input this cycle.
REQ-011 SHALL have port out_bit, output, 1: serial coded bit.
REQ-012 SHALL have port out_valid, output, 1: out_bit valid.
REQ-013 SHALL have port out_last, output, 1: final coded bit of frame.
REQ-014 SHALL have port out_ready, input, 1: downstream accepts out_bit.

Function
REQ-015 SHALL hold state register s[K-2:0] (s[K-2] = most recent past bit). Encode vector v = {x, s}.
REQ-016 SHALL compute codeword bit c[j] = XOR-reduce(G[j] & v) for j = 0..N-1.
REQ-017 SHALL complete an input transfer when in_valid && in_ready. It then latches c[N-1:0] into the output buffer, shifts s <= {x, s[K-2:1]}, and sets bit index idx = 0.
REQ-018 SHALL present c[idx] on out_bit with out_valid=1 while the buffer is occupied, in order c[0] first.
REQ-019 SHALL advance idx on out_valid && out_ready. The buffer empties after transfer of idx = N-1.
REQ-020 SHALL hold out_bit, out_valid and out_last stable while out_valid && !out_ready.
REQ-021 SHALL drive in_ready = (state == DATA) && (buffer empty || (out_ready && idx == N-1)). This gives gapless 1 bit/cycle output.
REQ-022 SHALL implement FSM states DATA and TAIL.
  - DATA -> TAIL: on accepted in_last when TERMINATE=1.
  - TAIL: encodes x=0 internally, K-1 times. Each tail symbol is loaded under the same buffer rule as REQ-021.
  - TAIL -> DATA: when the last tail symbol is loaded.
REQ-023 SHALL assert out_last only on bit idx = N-1 of the frame's final symbol: the last tail symbol if TERMINATE=1, otherwise the in_last symbol.
REQ-024 SHALL clear s to zero when the final symbol of a frame is loaded, so each frame starts from the zero state.
REQ-025 SHALL keep in_ready low throughout TAIL. in_valid in TAIL is ignored, not lost, because the source holds it.
REQ-026 SHALL size the tail counter as $clog2(K) bits and wrap it to 0 on TAIL exit.
REQ-027 SHALL treat in_last on a single-bit frame as a normal frame: 1 data symbol plus K-1 tail symbols.

Reset
REQ-028 SHALL on rst: s=0, buffer empty, idx=0, tail counter=0, state=DATA, out_valid=0, out_last=0, out_bit=0. in_ready is 1 on the first cycle after rst deasserts.
REQ-029 SHALL, if rst is asserted mid-frame, discard the partial frame and emit no out_last. Reset takes priority over every handshake in that cycle.

Structure
REQ-030 SHALL place default K, N, G, the legal-range limits, and the FSM state enum in shared package conv_pkg.
REQ-031 SHALL use one sub-module, conv_parity, which computes c[N-1:0] from v and G combinationally. The FSM, shift register and serializer stay in the top.
REQ-032 SHALL fail elaboration when K, N or TERMINATE is out of range.

Verification
REQ-033 SHALL cover: defaults, frame 1,0,1,1 (in_last on 4th), out_ready=1 -> out_bit 11 10 00 01 01 11, out_last on bit 12, no idle cycles.
REQ-034 SHALL cover: same frame with TERMINATE=0 -> 11 10 00 01, out_last on bit 8, s=0 afterwards.
REQ-035 SHALL cover: out_ready toggled randomly, 50% -> identical bit sequence to REQ-033, outputs stable while stalled, in_ready never high in TAIL.
REQ-036 SHALL cover: two back-to-back frames "1" and "1" -> 11 10 11 then 11 10 11. The second frame proves the state cleared.
REQ-037 SHALL cover: rst pulsed after 2nd data bit -> out_valid=0 next cycle, in_ready=1, the following frame encodes as from the zero state.
REQ-038 SHALL cover: K=7, N=2, G={171,133 octal}, 100 random frames -> matches the reference model bit-exact, including the 6 tail symbols.
